sha1_host_bridge: RTL and testbench

- Parametrised host-to-hash-core bridge between the Nios PIO register set (address, write, read, control, status) and NUM_CH independent sha1 cores.
- Converts software-driven level signals into a 4-phase req/ack handshake and issues single-cycle core strobes.
- Supports per-channel and broadcast writes, latency-aware read capture, and per-channel sticky error tracking.
- Sits in the wpa top level between the Nios system and the sha1 core array; replaces the direct one-core PIO wiring.

---
 rtl/sha1_bridge_pkg.sv | 34 +++
 rtl/sha1_rd_mux.sv | 54 +++++
 rtl/sha1_host_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_sha1_host_bridge.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha1_bridge_pkg.sv
// Shared definitions for the Nios-to-sha1 host bridge.
//   - bit positions inside the host control and status bytes
//   - FSM state encoding
//   - helper to size the channel select for a given channel count
package sha1_bridge_pkg;

    // host_control bit positions
    localparam int CTL_REQ     = 0;
    localparam int CTL_WE      = 1;
    localparam int CTL_BCAST   = 2;
    localparam int CTL_CH_LSB  = 3;
    localparam int CTL_CH_MSB  = 5;
    localparam int CTL_ERR_CLR = 6;
    localparam int CH_FIELD_W  = CTL_CH_MSB - CTL_CH_LSB + 1;

    // host_status bit positions (bits 7:4 are always zero)
    localparam int STS_ACK    = 0;
    localparam int STS_BUSY   = 1;
    localparam int STS_ERR    = 2;
    localparam int STS_BAD_CH = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        ACK     = 2'd3
    } state_t;

    // Width of the channel select actually needed to address n cores.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sha1_rd_mux.sv
// Registered NUM_CH:1 read-data slice select.
//   clk, reset_n : clock, synchronous active-low reset (clears o_data)
//   i_capture    : load the selected slice into o_data on this edge
//   i_clear      : force o_data to zero on this edge (illegal channel)
//   i_sel        : channel index of the slice to capture
//   i_bus        : concatenated read buses, channel i at [i*DATA_W +: DATA_W]
//   o_data       : held result, changes only on capture or clear
module sha1_rd_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_capture,
    input  logic                     i_clear,
    input  logic [SEL_W-1:0]         i_sel,
    input  logic [NUM_CH*DATA_W-1:0] i_bus,
    output logic [DATA_W-1:0]        o_data
);

    logic [DATA_W-1:0] w_slice [NUM_CH];
    logic [DATA_W-1:0] w_sel_data;
    logic [DATA_W-1:0] r_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_slice
            assign w_slice[gi] = i_bus[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_sel == SEL_W'(i)) begin
                w_sel_data = w_slice[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data <= '0;
        end else if (i_clear) begin
            r_data <= '0;
        end else if (i_capture) begin
            r_data <= w_sel_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/sha1_host_bridge.sv
// Bridge between the Nios PIO register set and NUM_CH sha1 cores.
// Turns the host's level-driven req into a 4-phase req/ack handshake and
// issues a single-cycle chip-select strobe per transaction.
//   clk, reset_n     : clock, synchronous active-low reset
//   host_address     : core register address
//   host_write_data  : write data
//   host_control     : [0] req [1] we [2] broadcast [5:3] channel [6] err_clr
//   host_read_data   : last completed read (0 after an illegal channel)
//   host_status      : [0] ack [1] busy [2] sticky err of latched channel [3] bad_ch
//   core_cs          : one-hot strobe, all ones on broadcast write
//   core_we/address/write_data : latched request fields, shared by all cores
//   core_read_data   : concatenated core read buses
//   core_error       : per-core error flags, accumulated into sticky bits
module sha1_host_bridge
    import sha1_bridge_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        host_address,
    input  logic [DATA_W-1:0]        host_write_data,
    input  logic [7:0]               host_control,
    output logic [DATA_W-1:0]        host_read_data,
    output logic [7:0]               host_status,
    output logic [NUM_CH-1:0]        core_cs,
    output logic                     core_we,
    output logic [ADDR_W-1:0]        core_address,
    output logic [DATA_W-1:0]        core_write_data,
    input  logic [NUM_CH*DATA_W-1:0] core_read_data,
    input  logic [NUM_CH-1:0]        core_error
);

    localparam int SEL_W = sel_width(NUM_CH);
    localparam int CNT_W = 3;

    // host control decode
    logic                  w_req;
    logic                  w_we;
    logic                  w_bcast;
    logic                  w_err_clr;
    logic [CH_FIELD_W-1:0] w_ch;
    logic                  w_ch_bad;
    logic                  w_unused;

    assign w_req     = host_control[CTL_REQ];
    assign w_we      = host_control[CTL_WE];
    assign w_bcast   = host_control[CTL_BCAST];
    assign w_err_clr = host_control[CTL_ERR_CLR];
    assign w_ch      = host_control[CTL_CH_MSB:CTL_CH_LSB];
    assign w_unused  = host_control[7];
    // The full 3-bit field is range-checked; only the low SEL_W bits select.
    assign w_ch_bad  = (int'(w_ch) >= NUM_CH);

    // state and latched request
    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we;
    logic                r_bcast;
    logic [SEL_W-1:0]    r_sel;
    logic                r_bad_ch;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_CH-1:0]   r_err_sticky;

    logic                w_start;
    logic                w_capture;
    logic                w_rd_clear;
    logic [NUM_CH-1:0]   w_in_onehot;
    logic [NUM_CH-1:0]   w_lat_onehot;
    logic [NUM_CH-1:0]   w_clr_mask;
    logic [NUM_CH-1:0]   w_cs;
    logic                w_err_sel;
    logic [7:0]          w_status;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_dec
            assign w_in_onehot[gi]  = (w_ch[SEL_W-1:0] == SEL_W'(gi));
            assign w_lat_onehot[gi] = (r_sel == SEL_W'(gi));
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        w_rd_clear   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_start      = 1'b1;
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (r_bad_ch) begin
                    w_rd_clear   = 1'b1;
                    w_state_next = ACK;
                end else if (r_we) begin
                    w_state_next = ACK;
                end else begin
                    w_state_next = WAIT_RD;
                end
            end
            WAIT_RD: begin
                // Counter value 1 marks the edge on which core data is valid.
                if (r_cnt == CNT_W'(1)) begin
                    w_capture    = 1'b1;
                    w_state_next = ACK;
                end
            end
            ACK: begin
                if (!w_req) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Strobe is decoded from registered state only, so it is clean for
    // exactly the ISSUE cycle. Broadcast is honoured for writes only.
    always_comb begin
        w_cs = '0;
        if (r_state == ISSUE && !r_bad_ch) begin
            w_cs = (r_we && r_bcast) ? '1 : w_lat_onehot;
        end
    end

    // err_clr acts directly on the start edge; it never needs to be stored.
    always_comb begin
        w_clr_mask = '0;
        if (w_start && w_err_clr) begin
            if (w_bcast) begin
                w_clr_mask = '1;
            end else if (!w_ch_bad) begin
                w_clr_mask = w_in_onehot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_bcast      <= 1'b0;
            r_sel        <= '0;
            r_bad_ch     <= 1'b0;
            r_cnt        <= '0;
            r_err_sticky <= '0;
        end else begin
            r_state <= w_state_next;
            // A new error on the clear cycle wins over the clear.
            r_err_sticky <= core_error | (r_err_sticky & ~w_clr_mask);
            if (w_start) begin
                r_addr   <= host_address;
                r_wdata  <= host_write_data;
                r_we     <= w_we;
                r_bcast  <= w_bcast;
                r_sel    <= w_ch[SEL_W-1:0];
                r_bad_ch <= w_ch_bad;
            end
            if (r_state == ISSUE) begin
                r_cnt <= CNT_W'(READ_LAT);
            end else if (r_state == WAIT_RD) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    sha1_rd_mux #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_rd_mux (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_capture (w_capture),
        .i_clear   (w_rd_clear),
        .i_sel     (r_sel),
        .i_bus     (core_read_data),
        .o_data    (host_read_data)
    );

    assign w_err_sel = r_bad_ch ? 1'b0 : |(r_err_sticky & w_lat_onehot);

    always_comb begin
        w_status             = '0;
        w_status[STS_ACK]    = (r_state == ACK);
        w_status[STS_BUSY]   = (r_state != IDLE);
        w_status[STS_ERR]    = w_err_sel;
        w_status[STS_BAD_CH] = r_bad_ch;
    end

    assign host_status     = w_status;
    assign core_cs         = w_cs;
    assign core_we         = r_we;
    assign core_address    = r_addr;
    assign core_write_data = r_wdata;

endmodule

// File: tb/tb_sha1_host_bridge.sv
module tb_sha1_host_bridge;
    import sha1_bridge_pkg::*;

    localparam int NCH = 4;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [AW-1:0]     host_address;
    logic [DW-1:0]     host_write_data;
    logic [7:0]        host_control;
    logic [DW-1:0]     host_read_data;
    logic [7:0]        host_status;
    logic [NCH-1:0]    core_cs;
    logic              core_we;
    logic [AW-1:0]     core_address;
    logic [DW-1:0]     core_write_data;
    logic [NCH*DW-1:0] core_read_data;
    logic [NCH-1:0]    core_error;

    sha1_host_bridge #(
        .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .host_address(host_address), .host_write_data(host_write_data),
        .host_control(host_control), .host_read_data(host_read_data),
        .host_status(host_status), .core_cs(core_cs), .core_we(core_we),
        .core_address(core_address), .core_write_data(core_write_data),
        .core_read_data(core_read_data), .core_error(core_error)
    );

    // Core model: register file per channel, read data valid for exactly
    // one cycle LAT cycles after the strobe, random junk otherwise.
    bit [31:0] core_mem [NCH][256];
    bit        core_wr  [NCH][256];
    bit [1:0]  pv   [NCH];
    bit [31:0] pd0  [NCH];
    bit [31:0] pd1  [NCH];
    bit [31:0] junk [NCH];

    function automatic logic [31:0] init_word(input int c, input int a);
        return 32'h9E3779B1 * 32'(c * 256 + a + 1);
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            pv[c]   <= {pv[c][0], core_cs[c] & ~core_we};
            pd0[c]  <= core_wr[c][core_address] ? core_mem[c][core_address]
                                                : init_word(c, int'(core_address));
            pd1[c]  <= pd0[c];
            junk[c] <= $urandom;
            if (core_cs[c] && core_we) begin
                core_mem[c][core_address] <= core_write_data;
                core_wr[c][core_address]  <= 1'b1;
            end
        end
    end

    always_comb begin
        core_read_data = '0;
        for (int c = 0; c < NCH; c++) begin
            core_read_data[c*DW +: DW] = pv[c][1] ? pd1[c] : junk[c];
        end
    end

    // Transaction-level reference model
    logic [31:0]    ref_mem [NCH][256];
    logic [NCH-1:0] ref_sticky;
    logic [31:0]    ref_rd;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ctl(input logic req, input logic we, input logic bc,
                                       input logic [2:0] ch, input logic clr);
        logic [7:0] c;
        c = '0;
        c[CTL_REQ] = req;
        c[CTL_WE] = we;
        c[CTL_BCAST] = bc;
        c[CTL_CH_MSB:CTL_CH_LSB] = ch;
        c[CTL_ERR_CLR] = clr;
        return c;
    endfunction

    function automatic logic [7:0] mk_status(input logic ack, input logic busy,
                                             input logic err, input logic bad);
        logic [7:0] s;
        s = '0;
        s[STS_ACK] = ack;
        s[STS_BUSY] = busy;
        s[STS_ERR] = err;
        s[STS_BAD_CH] = bad;
        return s;
    endfunction

    task automatic model_txn(input logic we, input logic bc, input logic [2:0] ch,
                             input logic [7:0] addr, input logic [31:0] data,
                             input logic clr, input logic [3:0] pulse,
                             output logic [3:0] m, output int a, output logic [31:0] rd,
                             output logic bad, output logic err);
        bad = (int'(ch) >= NCH);
        if (clr) begin
            if (bc) ref_sticky = '0;
            else if (!bad) ref_sticky[ch[1:0]] = 1'b0;
        end
        ref_sticky = ref_sticky | pulse;
        if (bad) m = '0;
        else if (we && bc) m = '1;
        else m = 4'b0001 << ch[1:0];
        a = (bad || we) ? 1 : LAT + 1;
        if (bad) begin
            ref_rd = '0;
        end else if (!we) begin
            ref_rd = ref_mem[ch[1:0]][addr];
        end else begin
            for (int c = 0; c < NCH; c++) if (m[c]) ref_mem[c][addr] = data;
        end
        rd  = ref_rd;
        err = bad ? 1'b0 : ref_sticky[ch[1:0]];
    endtask

    // Caller must be at a negedge. Ends at a negedge with DUT back in IDLE.
    task automatic run_txn(input logic we, input logic bc, input logic [2:0] ch,
                           input logic [7:0] addr, input logic [31:0] data,
                           input logic clr, input logic [3:0] pulse, input int hold,
                           input logic [3:0] exp_mask, input int exp_ack,
                           input logic [31:0] exp_rd, input logic exp_bad,
                           input logic exp_err, input string tag);
        int strobes, ack_cyc, lost;
        logic [7:0] st0;
        logic [3:0] cs0;
        logic we0;
        logic [7:0] a0;
        logic [31:0] d0;
        strobes = 0; ack_cyc = -1; lost = 0;
        st0 = '0; cs0 = '0; we0 = 1'b0; a0 = '0; d0 = '0;
        host_address    = addr;
        host_write_data = data;
        host_control    = ctl(1'b1, we, bc, ch, clr);
        core_error      = pulse;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                core_error = '0;
                st0 = host_status; cs0 = core_cs; we0 = core_we;
                a0 = core_address; d0 = core_write_data;
            end
            if (core_cs != '0) strobes++;
            if (host_status[STS_ACK]) begin
                ack_cyc = cyc;
                break;
            end
        end
        chk({tag, ".issue_status"}, 32'(st0), 32'(mk_status(1'b0, 1'b1, exp_err, exp_bad)));
        chk({tag, ".cs"}, 32'(cs0), 32'(exp_mask));
        if (exp_mask != '0) begin
            chk({tag, ".core_we"}, 32'(we0), 32'(we));
            chk({tag, ".core_addr"}, 32'(a0), 32'(addr));
            if (we) chk({tag, ".core_wdata"}, d0, data);
        end
        chk({tag, ".ack_cycle"}, 32'(ack_cyc), 32'(exp_ack));
        chk({tag, ".rd_data"}, host_read_data, exp_rd);
        chk({tag, ".ack_status"}, 32'(host_status), 32'(mk_status(1'b1, 1'b1, exp_err, exp_bad)));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (core_cs != '0) strobes++;
            if (!host_status[STS_ACK]) lost++;
        end
        chk({tag, ".strobe_count"}, 32'(strobes), (exp_mask != '0) ? 32'd1 : 32'd0);
        chk({tag, ".ack_held"}, 32'(lost), 32'd0);
        host_control = '0;
        @(negedge clk);
        chk({tag, ".idle_status"}, 32'(host_status), 32'(mk_status(1'b0, 1'b0, exp_err, exp_bad)));
        chk({tag, ".rd_hold"}, host_read_data, exp_rd);
        $display("txn %s: we=%0d bc=%0d ch=%0d addr=%02h cs=%b ack@%0d rd=%08h st=%02h",
                 tag, we, bc, ch, addr, cs0, ack_cyc, host_read_data, host_status);
    endtask

    task automatic do_model_txn(input logic we, input logic bc, input logic [2:0] ch,
                                input logic [7:0] addr, input logic [31:0] data,
                                input logic clr, input logic [3:0] pulse, input int hold,
                                input string tag);
        logic [3:0] m; int a; logic [31:0] rd; logic bad, err;
        model_txn(we, bc, ch, addr, data, clr, pulse, m, a, rd, bad, err);
        run_txn(we, bc, ch, addr, data, clr, pulse, hold, m, a, rd, bad, err, tag);
    endtask

    task automatic idle_pulse(input logic [3:0] p);
        core_error = p;
        ref_sticky = ref_sticky | p;
        @(negedge clk);
        core_error = '0;
    endtask

    typedef struct packed {
        logic        we;
        logic        bc;
        logic [2:0]  ch;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [7:0]  hold;
        logic [3:0]  exp_mask;
        logic [3:0]  exp_ack;
        logic [31:0] exp_rd;
        logic        exp_bad;
    } vec_t;

    vec_t vecs [10];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        logic [3:0] m; int a; logic [31:0] rd; logic bad, err;
        logic we, bc, clr; logic [2:0] ch; logic [7:0] addr; logic [3:0] pulse;

        vecs[0] = '{1'b1, 1'b0, 3'd2, 8'h10, 32'hDEADBEEF, 8'd5, 4'b0100, 4'd1, 32'h0,        1'b0};
        vecs[1] = '{1'b1, 1'b1, 3'd0, 8'h04, 32'h00000001, 8'd1, 4'b1111, 4'd1, 32'h0,        1'b0};
        vecs[2] = '{1'b0, 1'b1, 3'd1, 8'h04, 32'h0,        8'd0, 4'b0010, 4'd3, 32'h00000001, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 3'd3, 8'h20, 32'h67452301, 8'd2, 4'b1000, 4'd1, 32'h00000001, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 3'd3, 8'h20, 32'h0,        8'd3, 4'b1000, 4'd3, 32'h67452301, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 3'd0, 8'h30, 32'h00000055, 8'd0, 4'b0001, 4'd1, 32'h67452301, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 3'd6, 8'h10, 32'h0,        8'd2, 4'b0000, 4'd1, 32'h0,        1'b1};
        vecs[7] = '{1'b0, 1'b0, 3'd2, 8'h10, 32'h0,        8'd1, 4'b0100, 4'd3, 32'hDEADBEEF, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 3'd6, 8'h44, 32'h12345678, 8'd0, 4'b0000, 4'd1, 32'h0,        1'b1};
        vecs[9] = '{1'b0, 1'b0, 3'd0, 8'h04, 32'h0,        8'd0, 4'b0001, 4'd3, 32'h00000001, 1'b0};

        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < 256; i++) ref_mem[c][i] = init_word(c, i);
        ref_sticky = '0;
        ref_rd = '0;

        reset_n = 1'b0; host_address = '0; host_write_data = '0;
        host_control = '0; core_error = '0;
        repeat (3) @(negedge clk);
        chk("reset.status", 32'(host_status), 32'h0);
        chk("reset.rd_data", host_read_data, 32'h0);
        chk("reset.cs", 32'(core_cs), 32'h0);
        chk("reset.core_fields", {core_write_data[23:0], core_address}, 32'h0);
        chk("reset.core_we", 32'(core_we), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle.status", 32'(host_status), 32'h0);

        for (int i = 0; i < 10; i++) begin
            model_txn(vecs[i].we, vecs[i].bc, vecs[i].ch, vecs[i].addr, vecs[i].data,
                      1'b0, 4'b0, m, a, rd, bad, err);
            run_txn(vecs[i].we, vecs[i].bc, vecs[i].ch, vecs[i].addr, vecs[i].data,
                    1'b0, 4'b0, int'(vecs[i].hold), vecs[i].exp_mask, int'(vecs[i].exp_ack),
                    vecs[i].exp_rd, vecs[i].exp_bad, 1'b0, $sformatf("vec%0d", i));
        end

        // sticky error corner cases
        idle_pulse(4'b0010);
        do_model_txn(1'b0, 1'b0, 3'd1, 8'h04, 32'h0, 1'b0, 4'b0000, 0, "err_seen");
        do_model_txn(1'b1, 1'b0, 3'd1, 8'h50, 32'hA5A5A5A5, 1'b1, 4'b0000, 0, "err_clr");
        do_model_txn(1'b0, 1'b0, 3'd1, 8'h50, 32'h0, 1'b1, 4'b0010, 0, "err_set_wins");
        do_model_txn(1'b0, 1'b0, 3'd0, 8'h04, 32'h0, 1'b0, 4'b0000, 0, "err_other_ch");
        do_model_txn(1'b0, 1'b0, 3'd5, 8'h04, 32'h0, 1'b0, 4'b0000, 0, "err_bad_ch");
        do_model_txn(1'b1, 1'b1, 3'd1, 8'h60, 32'h0BADF00D, 1'b1, 4'b0000, 0, "err_bcast_clr");

        // reset in the middle of a read
        idle_pulse(4'b0100);
        host_address = 8'h10; host_write_data = '0;
        host_control = ctl(1'b1, 1'b0, 1'b0, 3'd2, 1'b0);
        @(negedge clk);
        chk("rst_seq.cs", 32'(core_cs), 32'h4);
        @(negedge clk);
        chk("rst_seq.wait_status", 32'(host_status),
            32'(mk_status(1'b0, 1'b1, ref_sticky[2], 1'b0)));
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_seq.status", 32'(host_status), 32'h0);
        chk("rst_seq.rd_data", host_read_data, 32'h0);
        chk("rst_seq.cs_after", 32'(core_cs), 32'h0);
        ref_sticky = '0;
        ref_rd = '0;
        reset_n = 1'b1;
        do_model_txn(1'b0, 1'b0, 3'd2, 8'h10, 32'h0, 1'b0, 4'b0000, 1, "after_rst");

        // randomized transactions
        for (int n = 0; n < 40; n++) begin
            we    = 1'($urandom_range(0, 1));
            bc    = ($urandom_range(0, 3) == 0);
            ch    = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            addr  = 8'($urandom_range(0, 5) << 4);
            clr   = ($urandom_range(0, 2) == 0);
            pulse = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            do_model_txn(we, bc, ch, addr, $urandom, clr, pulse,
                         $urandom_range(0, 2), $sformatf("rnd%0d", n));
            if ($urandom_range(0, 2) == 0) idle_pulse(4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
